bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Bus arbiter/interconnect for a serial bus with two masters (m1, m2) and three slaves (s1..s3).
- Grants the bus to one master at a time.
- Decodes a 2-bit slave ID from the granted master's serial address stream.
- Routes master→slave serial address/data/control and slave→master read data/valid through registered one-hot connection flags.

Parameters:
- SID_BITS, 2, slave-ID bits at head of each address frame (LSB first); ID 1/2/3 select s1/s2/s3, ID 0 invalid.
- NUM_SLAVES, 3, slave count (fixed; not meant to be overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m1_request, m2_request  in  1  bus request; held for whole tenure.
- m1_address, m2_address  in  1  serial address bit.
- m1_data, m2_data  in  1  serial write-data bit.
- m1_valid, m2_valid  in  1  serial stream valid.
- m1_address_valid, m2_address_valid  in  1  one-cycle pulse marking start of an address frame.
- m1_write_en, m2_write_en  in  1  write (1) / read (0).
- s1_data_in, s2_data_in, s3_data_in  in  1  serial read data from slave.
- s1_ready, s2_ready, s3_ready  in  1  slave ready.
- s1_valid_out, s2_valid_out, s3_valid_out  in  1  slave read-data valid.
- m1_data_out, m2_data_out  out  1  read data to master.
- m1_ready, m2_ready  out  1  connected slave ready.
- m1_available, m2_available  out  1  bus granted to this master.
- m1_valid_in, m2_valid_in  out  1  read-data valid to master.
- sN_address, sN_data, sN_valid, sN_write_en (N=1..3)  out  1 each  forwarded master signals.
- state  out  3  FSM state code.
- m1_connect1..3, m2_connect1..3  out  1 each  one-hot connection flags.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all connect flags 0.
  - All outputs 0; counters cleared; priority pointer = m1.
  - Reset mid-transfer drops the connection immediately.
- FSM states and codes:
  - IDLE 0.
  - M1_WAIT 1, M1_SID 2, M1_CONN 3.
  - M2_WAIT 4, M2_SID 5, M2_CONN 6.
  - Code 7 unused; decodes to IDLE.
- IDLE transitions:
  - m1_request only → M1_WAIT.
  - m2_request only → M2_WAIT.
  - Both → M1_WAIT (fixed priority).
- Grant:
  - mX_available=1 in every mX state.
  - No preemption: the other master's request is ignored until release.
- xWAIT: address_valid=1 at a posedge → xSID; SID bit counter cleared.
- xSID:
  - Shifts mX_address for SID_BITS cycles, LSB first.
  - After the last bit: ID 1..3 → xCONN, setting the matching mX_connectN one cycle later (registered).
  - ID 0 → back to xWAIT.
  - SID bits are not forwarded to slaves.
- xCONN forwarding (combinational):
  - sN_address/data/valid/write_en = mX signals for the connected N; unconnected slaves see 0.
  - mX_data_out = sN_data_in; mX_valid_in = sN_valid_out; mX_ready = sN_ready.
  - Non-granted master outputs are 0.
- Slave not ready: the connection is held, the master sees ready=0 and must stall its stream. The arbiter neither buffers nor drops bits.
- New address_valid from the granted master while in xCONN:
  - Connection cleared → xSID for re-decode.
  - Grant retained.
- Release:
  - mX_request=0 in any mX state → IDLE next cycle, connections cleared.
  - A pending request from the other master is granted from IDLE on the following cycle (one idle cycle between tenures).
- address_valid from a non-granted master is ignored.

Optional Feature:
- ROUND_ROBIN_EN defined:
  - On simultaneous requests in IDLE, the master not served last wins.
  - Pointer updates on each release.
- ROUND_ROBIN_EN undefined: m1 always wins ties.

Decomposition:
- Shared package bus_arbiter_pkg:
  - state enum and codes.
  - SID_BITS and slave-ID constants.
- Optional sub-module arb_sid_decoder, instantiated once per master: counter + shift register producing sid and done.

Test Plan:
- Reset: hold reset=0 → state=0 and all outputs 0. Release, m1_request=1 → state=1, m1_available=1.
- m1: address_valid pulse, SID bits 1,0 (ID=1) → state 2 then 3; m1_connect1=1. Toggling m1_address/m1_data appears on s1_address/s1_data the same cycle; s2/s3 stay 0.
- m1 sends second address_valid with ID=2 → m1_connect1=0, then m1_connect2=1. s2_ready=0 → m1_ready=0.
- m2_request=1 during m1 tenure → m2_available=0, state unchanged. m1_request=0 → IDLE, then M2_WAIT (4), m2_available=1.
- Read path: connected to s3, s3_data_in=1, s3_valid_out=1 → m1_data_out=1, m1_valid_in=1; m2_data_out=0.
- Both request in IDLE twice with releases between:
  - without ROUND_ROBIN_EN → m1 granted both times;
  - with ROUND_ROBIN_EN → m1 then m2.
- SID=0 → return to state 1, no connect flag set.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master / three-slave serial bus arbiter.
package bus_arbiter_pkg;

  localparam int SID_BITS    = 2;
  localparam int NUM_SLAVES  = 3;
  localparam int NUM_MASTERS = 2;

  localparam logic [SID_BITS-1:0] SID_INVALID = 2'd0;
  localparam logic [SID_BITS-1:0] SID_S1      = 2'd1;
  localparam logic [SID_BITS-1:0] SID_S2      = 2'd2;
  localparam logic [SID_BITS-1:0] SID_S3      = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    M1_WAIT = 3'd1,
    M1_SID  = 3'd2,
    M1_CONN = 3'd3,
    M2_WAIT = 3'd4,
    M2_SID  = 3'd5,
    M2_CONN = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    PH_WAIT = 2'd0,
    PH_SID  = 2'd1,
    PH_CONN = 2'd2
  } phase_t;

  // Master g occupies codes 1..3 (g=0) or 4..6 (g=1), ordered WAIT, SID, CONN.
  function automatic state_t state_encode(input logic g, input phase_t ph);
    return state_t'(3'd1 + (g ? 3'd3 : 3'd0) + {1'b0, ph});
  endfunction

  function automatic logic [NUM_SLAVES-1:0] sid_onehot(input logic [SID_BITS-1:0] sid);
    case (sid)
      SID_S1:  return 3'b001;
      SID_S2:  return 3'b010;
      SID_S3:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bus bundle of the arbiter: master-side and slave-side serial signals plus status.
// The master modport is the agents on the bus (masters and slave devices); slave is the arbiter.
interface bus_arbiter_if;

  logic m1_request, m2_request;
  logic m1_address, m2_address;
  logic m1_data, m2_data;
  logic m1_valid, m2_valid;
  logic m1_address_valid, m2_address_valid;
  logic m1_write_en, m2_write_en;
  logic s1_data_in, s2_data_in, s3_data_in;
  logic s1_ready, s2_ready, s3_ready;
  logic s1_valid_out, s2_valid_out, s3_valid_out;

  logic m1_data_out, m2_data_out;
  logic m1_ready, m2_ready;
  logic m1_available, m2_available;
  logic m1_valid_in, m2_valid_in;
  logic s1_address, s1_data, s1_valid, s1_write_en;
  logic s2_address, s2_data, s2_valid, s2_write_en;
  logic s3_address, s3_data, s3_valid, s3_write_en;
  logic [2:0] state;
  logic m1_connect1, m1_connect2, m1_connect3;
  logic m2_connect1, m2_connect2, m2_connect3;

  modport master (
    output m1_request, m2_request, m1_address, m2_address, m1_data, m2_data,
           m1_valid, m2_valid, m1_address_valid, m2_address_valid,
           m1_write_en, m2_write_en, s1_data_in, s2_data_in, s3_data_in,
           s1_ready, s2_ready, s3_ready, s1_valid_out, s2_valid_out, s3_valid_out,
    input  m1_data_out, m2_data_out, m1_ready, m2_ready, m1_available, m2_available,
           m1_valid_in, m2_valid_in,
           s1_address, s1_data, s1_valid, s1_write_en,
           s2_address, s2_data, s2_valid, s2_write_en,
           s3_address, s3_data, s3_valid, s3_write_en, state,
           m1_connect1, m1_connect2, m1_connect3, m2_connect1, m2_connect2, m2_connect3
  );

  modport slave (
    input  m1_request, m2_request, m1_address, m2_address, m1_data, m2_data,
           m1_valid, m2_valid, m1_address_valid, m2_address_valid,
           m1_write_en, m2_write_en, s1_data_in, s2_data_in, s3_data_in,
           s1_ready, s2_ready, s3_ready, s1_valid_out, s2_valid_out, s3_valid_out,
    output m1_data_out, m2_data_out, m1_ready, m2_ready, m1_available, m2_available,
           m1_valid_in, m2_valid_in,
           s1_address, s1_data, s1_valid, s1_write_en,
           s2_address, s2_data, s2_valid, s2_write_en,
           s3_address, s3_data, s3_valid, s3_write_en, state,
           m1_connect1, m1_connect2, m1_connect3, m2_connect1, m2_connect2, m2_connect3
  );

endinterface

// File: rtl/bus_arbiter_sid_decoder.sv
// Collects the LSB-first slave-ID bits at the head of an address frame.
// sid is valid in the cycle done is high (it includes the bit being sampled).
module arb_sid_decoder
  import bus_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                shift_en,
  input  logic                addr_bit,
  output logic [SID_BITS-1:0] sid,
  output logic                done
);

  localparam int CW = $clog2(SID_BITS + 1);

  logic [CW-1:0]       cnt_reg;
  logic [SID_BITS-2:0] sr_reg;
  logic [SID_BITS-1:0] sr_next;

  assign sr_next = {addr_bit, sr_reg};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
      sr_reg  <= '0;
    end else if (!shift_en) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
      sr_reg  <= sr_next[SID_BITS-1:1];
    end
  end

  assign sid  = sr_next;
  assign done = shift_en && (cnt_reg == CW'(SID_BITS - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Two-master / three-slave serial bus arbiter with slave-ID decode and registered routing.
// Define ROUND_ROBIN_EN to alternate tie-break priority; otherwise m1 wins ties.
module bus_arbiter
  import bus_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  bus_arbiter_if.slave bus
);

  logic [NUM_MASTERS-1:0] req, addr, data, vld, addr_vld, wen;
  logic [NUM_MASTERS-1:0] avail, shift_en, sid_done, m_data_out, m_ready, m_valid_in;
  logic [NUM_SLAVES-1:0]  s_data_in, s_ready, s_valid_out;
  logic [NUM_SLAVES-1:0]  s_address, s_data, s_valid, s_write_en;
  logic [SID_BITS-1:0]    sid [NUM_MASTERS];
  logic [NUM_SLAVES-1:0]  conn_reg [NUM_MASTERS];
  logic [NUM_SLAVES-1:0]  conn_next [NUM_MASTERS];
  state_t                 state_reg, state_next;
  logic                   active, g;
  phase_t                 phase;
  logic                   prio_reg;

  assign req       = {bus.m2_request, bus.m1_request};
  assign addr      = {bus.m2_address, bus.m1_address};
  assign data      = {bus.m2_data, bus.m1_data};
  assign vld       = {bus.m2_valid, bus.m1_valid};
  assign addr_vld  = {bus.m2_address_valid, bus.m1_address_valid};
  assign wen       = {bus.m2_write_en, bus.m1_write_en};
  assign s_data_in   = {bus.s3_data_in, bus.s2_data_in, bus.s1_data_in};
  assign s_ready     = {bus.s3_ready, bus.s2_ready, bus.s1_ready};
  assign s_valid_out = {bus.s3_valid_out, bus.s2_valid_out, bus.s1_valid_out};

  // Split the state code into granted master and tenure phase; code 7 reads as IDLE.
  always_comb begin
    active = 1'b1;
    g      = 1'b0;
    phase  = PH_WAIT;
    case (state_reg)
      M1_WAIT: phase = PH_WAIT;
      M1_SID:  phase = PH_SID;
      M1_CONN: phase = PH_CONN;
      M2_WAIT: begin g = 1'b1; phase = PH_WAIT; end
      M2_SID:  begin g = 1'b1; phase = PH_SID;  end
      M2_CONN: begin g = 1'b1; phase = PH_CONN; end
      default: active = 1'b0;
    endcase
  end

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign shift_en[gi] = active && (g == 1'(gi)) && (phase == PH_SID);

      arb_sid_decoder u_sid (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en[gi]),
        .addr_bit (addr[gi]),
        .sid      (sid[gi]),
        .done     (sid_done[gi])
      );

      assign m_data_out[gi] = |(conn_reg[gi] & s_data_in);
      assign m_ready[gi]    = |(conn_reg[gi] & s_ready);
      assign m_valid_in[gi] = |(conn_reg[gi] & s_valid_out);
    end

    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      assign s_address[gi]  = (conn_reg[0][gi] & addr[0]) | (conn_reg[1][gi] & addr[1]);
      assign s_data[gi]     = (conn_reg[0][gi] & data[0]) | (conn_reg[1][gi] & data[1]);
      assign s_valid[gi]    = (conn_reg[0][gi] & vld[0])  | (conn_reg[1][gi] & vld[1]);
      assign s_write_en[gi] = (conn_reg[0][gi] & wen[0])  | (conn_reg[1][gi] & wen[1]);
    end
  endgenerate

`ifdef ROUND_ROBIN_EN
  logic prio_next;

  // prio_reg=1 means m2 wins the next tie; a releasing master hands priority over.
  always_comb begin
    prio_next = prio_reg;
    if (active && !req[g]) prio_next = ~g;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prio_reg <= 1'b0;
    else        prio_reg <= prio_next;
  end
`else
  assign prio_reg = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      for (int i = 0; i < NUM_MASTERS; i++) conn_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      conn_reg  <= conn_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    conn_next  = conn_reg;
    if (!active || !req[g]) begin
      conn_next[0] = '0;
      conn_next[1] = '0;
      state_next   = IDLE;
      if (!active) begin
        if (req[0] && !(req[1] && prio_reg)) state_next = M1_WAIT;
        else if (req[1])                     state_next = M2_WAIT;
      end
    end else begin
      case (phase)
        PH_WAIT: if (addr_vld[g]) state_next = state_encode(g, PH_SID);
        PH_SID: begin
          if (sid_done[g]) begin
            if (sid[g] != SID_INVALID) begin
              state_next   = state_encode(g, PH_CONN);
              conn_next[g] = sid_onehot(sid[g]);
            end else begin
              state_next = state_encode(g, PH_WAIT);
            end
          end
        end
        default: begin
          if (addr_vld[g]) begin
            state_next   = state_encode(g, PH_SID);
            conn_next[g] = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    avail = '0;
    if (active) avail[g] = 1'b1;
  end

  assign bus.state        = state_reg;
  assign bus.m1_available = avail[0];
  assign bus.m2_available = avail[1];
  assign bus.m1_data_out  = m_data_out[0];
  assign bus.m2_data_out  = m_data_out[1];
  assign bus.m1_ready     = m_ready[0];
  assign bus.m2_ready     = m_ready[1];
  assign bus.m1_valid_in  = m_valid_in[0];
  assign bus.m2_valid_in  = m_valid_in[1];
  assign {bus.s3_address, bus.s2_address, bus.s1_address}    = s_address;
  assign {bus.s3_data, bus.s2_data, bus.s1_data}             = s_data;
  assign {bus.s3_valid, bus.s2_valid, bus.s1_valid}          = s_valid;
  assign {bus.s3_write_en, bus.s2_write_en, bus.s1_write_en} = s_write_en;
  assign {bus.m1_connect3, bus.m1_connect2, bus.m1_connect1} = conn_reg[0];
  assign {bus.m2_connect3, bus.m2_connect2, bus.m2_connect1} = conn_reg[1];

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed test of bus_arbiter: grant, SID decode, routing, release, tie-break, async reset.
module tb_bus_arbiter;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  bus_arbiter_if bus_if ();

  bus_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] conns();
    return {bus_if.m2_connect3, bus_if.m2_connect2, bus_if.m2_connect1,
            bus_if.m1_connect3, bus_if.m1_connect2, bus_if.m1_connect1};
  endfunction

  function automatic logic [31:0] all_outs();
    return {bus_if.m1_data_out, bus_if.m2_data_out, bus_if.m1_ready, bus_if.m2_ready,
            bus_if.m1_available, bus_if.m2_available, bus_if.m1_valid_in, bus_if.m2_valid_in,
            bus_if.s1_address, bus_if.s1_data, bus_if.s1_valid, bus_if.s1_write_en,
            bus_if.s2_address, bus_if.s2_data, bus_if.s2_valid, bus_if.s2_write_en,
            bus_if.s3_address, bus_if.s3_data, bus_if.s3_valid, bus_if.s3_write_en,
            bus_if.state, conns()};
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    {bus_if.m1_request, bus_if.m2_request, bus_if.m1_address, bus_if.m2_address} = '0;
    {bus_if.m1_data, bus_if.m2_data, bus_if.m1_valid, bus_if.m2_valid} = '0;
    {bus_if.m1_address_valid, bus_if.m2_address_valid, bus_if.m1_write_en, bus_if.m2_write_en} = '0;
    {bus_if.s1_data_in, bus_if.s2_data_in, bus_if.s3_data_in} = '0;
    {bus_if.s1_ready, bus_if.s2_ready, bus_if.s3_ready} = '0;
    {bus_if.s1_valid_out, bus_if.s2_valid_out, bus_if.s3_valid_out} = '0;

    // Held in reset with activity on the inputs: everything stays at zero.
    bus_if.m1_request = 1'b1;
    bus_if.s1_ready   = 1'b1;
    tick();
    tick();
    check("reset_outputs", all_outs(), 32'd0);

    reset = 1'b1;
    tick();
    check("grant_m1_state", 32'(bus_if.state), 32'd1);
    check("grant_m1_avail", 32'({bus_if.m2_available, bus_if.m1_available}), 32'b01);

    // Frame to slave 1: SID bits 1,0 (LSB first).
    bus_if.m1_address_valid = 1'b1;
    tick();
    check("m1_sid_state", 32'(bus_if.state), 32'd2);
    bus_if.m1_address_valid = 1'b0;
    bus_if.m1_address = 1'b1;
    tick();
    check("m1_sid_bit0_state", 32'(bus_if.state), 32'd2);
    bus_if.m1_address = 1'b0;
    tick();
    check("m1_conn_state", 32'(bus_if.state), 32'd3);
    check("m1_conn1", 32'(conns()), 32'b000001);

    {bus_if.m1_address, bus_if.m1_data, bus_if.m1_valid, bus_if.m1_write_en} = 4'b1111;
    #1;
    check("s1_fwd_all", 32'({bus_if.s1_address, bus_if.s1_data, bus_if.s1_valid, bus_if.s1_write_en}), 32'hF);
    check("s23_quiet", 32'({bus_if.s2_address, bus_if.s2_data, bus_if.s2_valid, bus_if.s2_write_en,
                            bus_if.s3_address, bus_if.s3_data, bus_if.s3_valid, bus_if.s3_write_en}), 32'h0);
    bus_if.m1_address = 1'b0;
    #1;
    check("s1_fwd_toggle", 32'({bus_if.s1_address, bus_if.s1_data}), 32'b01);
    check("m1_ready_s1", 32'(bus_if.m1_ready), 32'd1);

    // Re-decode to slave 2 (bits 0,1) within the same tenure.
    {bus_if.m1_data, bus_if.m1_valid, bus_if.m1_write_en} = 3'b000;
    bus_if.m1_address_valid = 1'b1;
    tick();
    check("redecode_state", 32'(bus_if.state), 32'd2);
    check("redecode_conn_clr", 32'(conns()), 32'd0);
    bus_if.m1_address_valid = 1'b0;
    bus_if.m1_address = 1'b0;
    tick();
    bus_if.m1_address = 1'b1;
    tick();
    check("m1_conn2", 32'(conns()), 32'b000010);
    bus_if.s2_ready = 1'b0;
    #1;
    check("m1_ready_s2_low", 32'(bus_if.m1_ready), 32'd0);
    bus_if.s2_ready = 1'b1;
    #1;
    check("m1_ready_s2_high", 32'(bus_if.m1_ready), 32'd1);
    check("s2_addr_fwd", 32'({bus_if.s2_address, bus_if.s1_address}), 32'b10);

    // m2 requests and pulses address_valid during m1 tenure: ignored.
    bus_if.m2_request = 1'b1;
    bus_if.m2_address_valid = 1'b1;
    tick();
    bus_if.m2_address_valid = 1'b0;
    check("no_preempt_state", 32'(bus_if.state), 32'd3);
    check("no_preempt_avail", 32'(bus_if.m2_available), 32'd0);

    // Re-decode to slave 3 (bits 1,1) and exercise the read path.
    bus_if.m1_address_valid = 1'b1;
    tick();
    bus_if.m1_address_valid = 1'b0;
    bus_if.m1_address = 1'b1;
    tick();
    tick();
    check("m1_conn3", 32'(conns()), 32'b000100);
    bus_if.s3_data_in   = 1'b1;
    bus_if.s3_valid_out = 1'b1;
    #1;
    check("read_path_m1", 32'({bus_if.m1_data_out, bus_if.m1_valid_in}), 32'b11);
    check("read_path_m2", 32'({bus_if.m2_data_out, bus_if.m2_valid_in}), 32'b00);

    // Release: one idle cycle, then m2 is granted.
    bus_if.m1_request = 1'b0;
    bus_if.m1_address = 1'b0;
    tick();
    check("release_state", 32'(bus_if.state), 32'd0);
    check("release_conn", 32'(conns()), 32'd0);
    check("release_read_dropped", 32'({bus_if.m1_data_out, bus_if.m1_valid_in, bus_if.m1_available}), 32'd0);
    tick();
    check("grant_m2_state", 32'(bus_if.state), 32'd4);
    check("grant_m2_avail", 32'({bus_if.m2_available, bus_if.m1_available}), 32'b10);

    // SID 0 from m2: back to M2_WAIT, no connection.
    bus_if.m2_address_valid = 1'b1;
    tick();
    check("m2_sid_state", 32'(bus_if.state), 32'd5);
    bus_if.m2_address_valid = 1'b0;
    bus_if.m2_address = 1'b0;
    tick();
    tick();
    check("sid0_state", 32'(bus_if.state), 32'd4);
    check("sid0_conn", 32'(conns()), 32'd0);

    // Tie-break twice, with a release in between.
    bus_if.m2_request = 1'b0;
    tick();
    check("m2_release_state", 32'(bus_if.state), 32'd0);
    bus_if.m1_request = 1'b1;
    bus_if.m2_request = 1'b1;
    tick();
    check("tie1_state", 32'(bus_if.state), 32'd1);
    bus_if.m1_request = 1'b0;
    tick();
    bus_if.m1_request = 1'b1;
    tick();
`ifdef ROUND_ROBIN_EN
    check("tie2_state", 32'(bus_if.state), 32'd4);
`else
    check("tie2_state", 32'(bus_if.state), 32'd1);
`endif

    // Asynchronous reset mid-transfer drops the connection at once.
    bus_if.m1_request = 1'b0;
    bus_if.m2_request = 1'b0;
    tick();
    bus_if.m1_request = 1'b1;
    tick();
    bus_if.m1_address_valid = 1'b1;
    tick();
    bus_if.m1_address_valid = 1'b0;
    bus_if.m1_address = 1'b0;
    tick();
    bus_if.m1_address = 1'b1;
    tick();
    bus_if.m1_valid = 1'b1;
    #1;
    check("pre_reset_s2", 32'({bus_if.s2_address, bus_if.s2_valid}), 32'b11);
    reset = 1'b0;
    #1;
    check("async_reset_state", 32'(bus_if.state), 32'd0);
    check("async_reset_outs", all_outs(), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
